// File: rtl/stream_ctrl_pkg.sv
// stream_ctrl_pkg: shared state encoding and trigger mode constants for the capture controller
package stream_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;
  localparam logic [1:0] TRIG_RISE  = 2'd0;
  localparam logic [1:0] TRIG_FALL  = 2'd1;
  localparam logic [1:0] TRIG_LEVEL = 2'd2;
  localparam logic [1:0] TRIG_SW    = 2'd3;
endpackage

// File: rtl/stream_ring_fifo.sv
// stream_ring_fifo: register-based first-word-fall-through ring buffer with drop-oldest and clear
module stream_ring_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  drop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic rm;
  always_comb begin
    rm = pop | drop;
    wr_d = clear ? '0 : wr_q + AW'(push);
    rd_d = clear ? '0 : rd_q + AW'(rm);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(rm);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // data storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/stream_capture_ctrl.sv
// stream_capture_ctrl: pre/post-trigger AXI-Stream capture with multi-frame re-arming
module stream_capture_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PRE_DEPTH  = 256,
  parameter int CNT_WIDTH  = 32,
  localparam int AW = $clog2(PRE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [AW:0]           pre_samples,
  input  logic [CNT_WIDTH-1:0]  post_samples,
  input  logic [15:0]           frames,
  input  logic [1:0]            trig_mode,
  input  logic                  arm,
  input  logic                  sw_trig,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] stream_i_tdata,
  input  logic                  stream_i_tvalid,
  output logic                  stream_i_tready,
  output logic [DATA_WIDTH-1:0] stream_o_tdata,
  output logic                  stream_o_tvalid,
  output logic                  stream_o_tlast,
  output logic                  stream_o_tuser,
  input  logic                  stream_o_tready,
  output logic                  busy,
  output logic                  armed,
  output logic                  done,
  output logic [15:0]           frame_cnt
);
  state_t state_q, state_d;
  logic trig_old_q, done_q, done_d;
  logic [AW:0] pre_cnt_q, pre_cnt_d, pre_clamp, fifo_count;
  logic [CNT_WIDTH:0] frame_len_q, frame_len_d, out_idx_q, out_idx_d;
  logic [CNT_WIDTH-1:0] post_rem_q, post_rem_d, post_eff;
  logic [15:0] frame_cnt_q, frame_cnt_d, frames_eff;
  logic trig_evt, last_frame, last_hs, push, pop, drop, clear, full, empty;
  assign pre_clamp = pre_samples > (AW+1)'(PRE_DEPTH) ? (AW+1)'(PRE_DEPTH) : pre_samples;
  assign post_eff = post_samples == '0 ? CNT_WIDTH'(1) : post_samples;
  assign frames_eff = frames == '0 ? 16'd1 : frames;
  assign last_frame = frame_cnt_q + 16'd1 == frames_eff;
  assign trig_evt = !abort && state_q == S_ARMED && (sw_trig
    || (trig_mode == TRIG_RISE && trig && !trig_old_q)
    || (trig_mode == TRIG_FALL && !trig && trig_old_q)
    || (trig_mode == TRIG_LEVEL && trig));
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      trig_old_q <= 1'b0;
      done_q <= 1'b0;
      pre_cnt_q <= '0;
      frame_len_q <= '0;
      out_idx_q <= '0;
      post_rem_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      trig_old_q <= trig;
      done_q <= done_d;
      pre_cnt_q <= pre_cnt_d;
      frame_len_q <= frame_len_d;
      out_idx_q <= out_idx_d;
      post_rem_q <= post_rem_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (abort) state_d = S_IDLE;
    else if (state_q == S_IDLE && arm) state_d = S_ARMED;
    else if (trig_evt) state_d = S_CAPTURE;
    else if (last_hs) state_d = last_frame ? S_IDLE : S_ARMED;
    pre_cnt_d = trig_evt ? fifo_count : pre_cnt_q;
    frame_len_d = trig_evt ? (CNT_WIDTH+1)'(fifo_count) + {1'b0, post_eff} : frame_len_q;
    post_rem_d = trig_evt ? post_eff - CNT_WIDTH'(push)
               : (state_q == S_CAPTURE && push) ? post_rem_q - 1'b1 : post_rem_q;
    out_idx_d = clear ? '0 : out_idx_q + (CNT_WIDTH+1)'(pop);
    frame_cnt_d = (state_q == S_IDLE && arm && !abort) ? '0
                : last_hs ? frame_cnt_q + 16'd1 : frame_cnt_q;
    done_d = last_hs && last_frame;
  end
  // the trigger beat is a post sample, so a full buffer stalls it rather than evicting a pre sample
  always_comb begin
    stream_i_tready = !abort && (state_q == S_ARMED ? !(full && trig_evt)
                    : state_q == S_CAPTURE && post_rem_q != '0 && !full);
    stream_o_tvalid = !abort && state_q == S_CAPTURE && !empty;
    push = stream_i_tvalid && stream_i_tready;
    pop = stream_o_tvalid && stream_o_tready;
    drop = state_q == S_ARMED && push && !trig_evt && fifo_count == pre_clamp;
    stream_o_tuser = stream_o_tvalid && out_idx_q == (CNT_WIDTH+1)'(pre_cnt_q);
    stream_o_tlast = stream_o_tvalid && out_idx_q == frame_len_q - 1'b1;
    last_hs = pop && stream_o_tlast;
    clear = abort || (state_q == S_IDLE && arm) || last_hs;
  end
  stream_ring_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(PRE_DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .pop(pop), .drop(drop), .clear(clear),
    .din(stream_i_tdata), .dout(stream_o_tdata), .full(full), .empty(empty), .count(fifo_count)
  );
  assign busy = state_q != S_IDLE;
  assign armed = state_q == S_ARMED;
  assign done = done_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_stream_capture_ctrl.sv
// tb_stream_capture_ctrl: directed scenarios for stream_capture_ctrl with hand-computed frames
module tb_stream_capture_ctrl;
  import stream_ctrl_pkg::*;
  localparam int DW = 16, PD = 8, CW = 16;
  logic clk = 0, resetn = 0;
  logic [3:0] pre_samples = '0;
  logic [CW-1:0] post_samples = '0;
  logic [15:0] frames = '0;
  logic [1:0] trig_mode = '0;
  logic arm = 0, sw_trig = 0, abort = 0, trig = 0;
  logic [DW-1:0] stream_i_tdata = '0, stream_o_tdata;
  logic stream_i_tvalid = 0, stream_i_tready, stream_o_tvalid, stream_o_tlast, stream_o_tuser;
  logic stream_o_tready = 0, busy, armed, done;
  logic [15:0] frame_cnt;
  int val, trig_val = -1, trig_end = 1 << 30, sw_val = -1, cyc, arun;
  bit in_valid, tog, sw_auto, arm_req, abort_req, fc_pend, cap_seen, cap_rdy;
  int done_n, done_cyc, last_cyc, last_n, total, bad;
  int dq[$], uq[$], lq[$], fcq[$];

  stream_capture_ctrl #(.DATA_WIDTH(DW), .PRE_DEPTH(PD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .pre_samples(pre_samples), .post_samples(post_samples),
    .frames(frames), .trig_mode(trig_mode), .arm(arm), .sw_trig(sw_trig), .abort(abort),
    .trig(trig), .stream_i_tdata(stream_i_tdata), .stream_i_tvalid(stream_i_tvalid),
    .stream_i_tready(stream_i_tready), .stream_o_tdata(stream_o_tdata),
    .stream_o_tvalid(stream_o_tvalid), .stream_o_tlast(stream_o_tlast),
    .stream_o_tuser(stream_o_tuser), .stream_o_tready(stream_o_tready),
    .busy(busy), .armed(armed), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      arm = arm_req; arm_req = 0;
      abort = abort_req; abort_req = 0;
      trig = trig_val >= 0 && val >= trig_val && val < trig_end;
      sw_trig = armed && ((sw_auto && arun == 3) || val == sw_val);
      stream_i_tvalid = in_valid;
      stream_i_tdata = val[DW-1:0];
      stream_o_tready = tog ? cyc[0] : 1'b1;
      #1;
      if (fc_pend) begin fcq.push_back(int'(frame_cnt)); fc_pend = 0; end
      if (busy && !armed && !cap_seen) begin cap_seen = 1; cap_rdy = stream_i_tready; end
      if (stream_o_tvalid && stream_o_tready) begin
        dq.push_back(int'(stream_o_tdata)); uq.push_back(int'(stream_o_tuser)); lq.push_back(int'(stream_o_tlast));
        if (stream_o_tlast) begin last_n++; last_cyc = cyc; fc_pend = 1; end
      end
      if (done) begin done_n++; done_cyc = cyc; end
      if (stream_i_tvalid && stream_i_tready) val++;
      arun = armed ? arun + 1 : 0;
      cyc++;
    end
  endtask

  task automatic start(input int pre, input int post, input int nf, input logic [1:0] mode);
    pre_samples = 4'(pre); post_samples = CW'(post); frames = 16'(nf); trig_mode = mode;
    dq.delete(); uq.delete(); lq.delete(); fcq.delete();
    val = 0; trig_val = -1; trig_end = 1 << 30; sw_val = -1; sw_auto = 0; tog = 0; in_valid = 1;
    done_n = 0; last_n = 0; cap_seen = 0; fc_pend = 0; arm_req = 1;
  endtask

  task automatic test_reset;
    resetn = 0;
    run(2);
    total++; if ({busy, armed, done, stream_o_tvalid, stream_i_tready, stream_o_tlast, stream_o_tuser} !== 7'b0)
      begin bad++; $display("FAIL reset_outputs got %b exp 0000000", {busy, armed, done, stream_o_tvalid, stream_i_tready, stream_o_tlast, stream_o_tuser}); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    resetn = 1;
    run(1);
  endtask

  task automatic test_frame;
    start(4, 3, 0, TRIG_RISE);
    trig_val = 10;
    run(30);
    total++; if (dq.size() !== 7) begin bad++; $display("FAIL frame_beats got %0d exp 7", dq.size()); end
    for (int i = 0; i < 7 && i < dq.size(); i++) begin
      total++; if (dq[i] !== 6 + i || uq[i] !== int'(i == 4) || lq[i] !== int'(i == 6))
        begin bad++; $display("FAIL frame_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], 6 + i, i == 4, i == 6); end
    end
    total++; if (cap_rdy !== 1'b1) begin bad++; $display("FAIL frame_cap_ready got %0d exp 1", cap_rdy); end
    total++; if (done_n !== 1 || done_cyc !== last_cyc + 1)
      begin bad++; $display("FAIL frame_done got n=%0d at %0d exp n=1 at %0d", done_n, done_cyc, last_cyc + 1); end
    total++; if (busy !== 1'b0 || frame_cnt !== 16'd1) begin bad++; $display("FAIL frame_end got busy=%0d fc=%0d exp busy=0 fc=1", busy, frame_cnt); end
  endtask

  task automatic test_early;
    start(4, 3, 1, TRIG_RISE);
    trig_val = 2;
    run(25);
    total++; if (dq.size() !== 5) begin bad++; $display("FAIL early_beats got %0d exp 5", dq.size()); end
    for (int i = 0; i < 5 && i < dq.size(); i++) begin
      total++; if (dq[i] !== i || uq[i] !== int'(i == 2) || lq[i] !== int'(i == 4))
        begin bad++; $display("FAIL early_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], i, i == 2, i == 4); end
    end
  endtask

  task automatic test_multi_frame;
    start(2, 2, 3, TRIG_RISE);
    sw_auto = 1;
    run(50);
    total++; if (dq.size() !== 12 || last_n !== 3) begin bad++; $display("FAIL multi_beats got %0d/%0d exp 12/3", dq.size(), last_n); end
    for (int i = 0; i < 12 && i < dq.size(); i++) begin
      total++; if (dq[i] !== 5 * (i / 4) + 1 + i % 4 || uq[i] !== int'(i % 4 == 2) || lq[i] !== int'(i % 4 == 3))
        begin bad++; $display("FAIL multi_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], 5 * (i / 4) + 1 + i % 4, i % 4 == 2, i % 4 == 3); end
    end
    total++; if (fcq.size() !== 3 || fcq[0] !== 1 || fcq[1] !== 2 || fcq[2] !== 3)
      begin bad++; $display("FAIL multi_frame_cnt got %p exp 1 2 3", fcq); end
    total++; if (done_n !== 1 || done_cyc !== last_cyc + 1)
      begin bad++; $display("FAIL multi_done got n=%0d at %0d exp n=1 at %0d", done_n, done_cyc, last_cyc + 1); end
  endtask

  task automatic test_backpressure;
    start(8, 5, 1, TRIG_RISE);
    trig_val = 12; tog = 1;
    run(70);
    total++; if (dq.size() !== 13) begin bad++; $display("FAIL bp_beats got %0d exp 13", dq.size()); end
    for (int i = 0; i < 13 && i < dq.size(); i++) begin
      total++; if (dq[i] !== 4 + i || uq[i] !== int'(i == 8) || lq[i] !== int'(i == 12))
        begin bad++; $display("FAIL bp_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], 4 + i, i == 8, i == 12); end
    end
    total++; if (cap_rdy !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %0d exp 0", cap_rdy); end
  endtask

  task automatic test_abort_reset;
    start(4, 6, 1, TRIG_RISE);
    trig_val = 6; tog = 1;
    run(12);
    total++; if (busy !== 1'b1 || armed !== 1'b0) begin bad++; $display("FAIL abort_pre got busy=%0d armed=%0d exp 1 0", busy, armed); end
    abort_req = 1;
    run(2);
    total++; if ({busy, armed, stream_o_tvalid, stream_i_tready, stream_o_tlast, stream_o_tuser} !== 6'b0 || last_n !== 0 || done_n !== 0)
      begin bad++; $display("FAIL abort_idle got %b last=%0d done=%0d exp 000000 0 0", {busy, armed, stream_o_tvalid, stream_i_tready, stream_o_tlast, stream_o_tuser}, last_n, done_n); end
    start(4, 3, 1, TRIG_RISE);
    trig_val = 10;
    run(30);
    total++; if (dq.size() !== 7 || dq[0] !== 6 || dq[6] !== 12 || lq[6] !== 1 || done_n !== 1)
      begin bad++; $display("FAIL abort_rearm got n=%0d first=%0d exp n=7 first=6", dq.size(), dq.size() ? dq[0] : -1); end
    start(4, 6, 1, TRIG_RISE);
    trig_val = 6; tog = 1;
    run(12);
    resetn = 0;
    run(1);
    resetn = 1;
    total++; if ({busy, armed, done, stream_o_tvalid, stream_i_tready, stream_o_tlast, stream_o_tuser} !== 7'b0 || frame_cnt !== 16'd0 || last_n !== 0)
      begin bad++; $display("FAIL midreset got %b fc=%0d last=%0d exp 0000000 0 0", {busy, armed, done, stream_o_tvalid, stream_i_tready, stream_o_tlast, stream_o_tuser}, frame_cnt, last_n); end
    start(2, 2, 1, TRIG_RISE);
    trig_val = 4;
    run(25);
    total++; if (dq.size() !== 4) begin bad++; $display("FAIL postreset_beats got %0d exp 4", dq.size()); end
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      total++; if (dq[i] !== 2 + i || uq[i] !== int'(i == 2) || lq[i] !== int'(i == 3))
        begin bad++; $display("FAIL postreset_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], 2 + i, i == 2, i == 3); end
    end
  endtask

  task automatic test_trig_modes;
    start(4, 2, 1, TRIG_FALL);
    trig_val = 2; trig_end = 5;
    run(25);
    total++; if (dq.size() !== 6) begin bad++; $display("FAIL fall_beats got %0d exp 6", dq.size()); end
    for (int i = 0; i < 6 && i < dq.size(); i++) begin
      total++; if (dq[i] !== 1 + i || uq[i] !== int'(i == 4) || lq[i] !== int'(i == 5))
        begin bad++; $display("FAIL fall_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], 1 + i, i == 4, i == 5); end
    end
    start(4, 0, 1, TRIG_SW);
    trig_val = 1; sw_val = 6;
    run(25);
    total++; if (dq.size() !== 5) begin bad++; $display("FAIL sw_beats got %0d exp 5", dq.size()); end
    for (int i = 0; i < 5 && i < dq.size(); i++) begin
      total++; if (dq[i] !== 2 + i || uq[i] !== int'(i == 4) || lq[i] !== int'(i == 4))
        begin bad++; $display("FAIL sw_beat%0d got d=%0d u=%0d l=%0d exp d=%0d u=%0d l=%0d", i, dq[i], uq[i], lq[i], 2 + i, i == 4, i == 4); end
    end
    trig_val = -1;
    run(2);
    start(4, 3, 1, TRIG_RISE);
    trig_val = 0;
    run(10);
    total++; if (armed !== 1'b1 || dq.size() !== 0) begin bad++; $display("FAIL arm_with_trig got armed=%0d beats=%0d exp 1 0", armed, dq.size()); end
    abort_req = 1;
    run(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arm_with_trig_abort got busy=%0d exp 0", busy); end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_early;
    test_multi_frame;
    test_backpressure;
    test_abort_reset;
    test_trig_modes;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
